// File: rtl/axi_lite_ram_ctrl.sv
// axi_lite_ram_ctrl: AXI4-Lite subordinate driving a Simple_RAM write/read port pair.
// Optional `AXI_RAM_ALIGN_CHECK_EN rejects unaligned addresses with SLVERR.
module axi_lite_ram_ctrl #(
   parameter int NUM_SLOTS        = 6,
   parameter int DATA_WIDTH_BYTES = 4,
   parameter int AXI_ADDR_WIDTH   = 32,
   localparam int ADDR_WIDTH_BITS = $clog2(NUM_SLOTS),
   localparam int DATA_WIDTH_BITS = 8 * DATA_WIDTH_BYTES,
   localparam int LSB             = $clog2(DATA_WIDTH_BYTES)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr,
   input  logic                        s_awvalid,
   output logic                        s_awready,
   input  logic [DATA_WIDTH_BITS-1:0]  s_wdata,
   input  logic [DATA_WIDTH_BYTES-1:0] s_wstrb,
   input  logic                        s_wvalid,
   output logic                        s_wready,
   output logic [1:0]                  s_bresp,
   output logic                        s_bvalid,
   input  logic                        s_bready,
   input  logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
   input  logic                        s_arvalid,
   output logic                        s_arready,
   output logic [DATA_WIDTH_BITS-1:0]  s_rdata,
   output logic [1:0]                  s_rresp,
   output logic                        s_rvalid,
   input  logic                        s_rready,
   output logic                        ram_w_en,
   output logic [ADDR_WIDTH_BITS-1:0]  ram_w_addr,
   output logic [DATA_WIDTH_BITS-1:0]  ram_w_data,
   output logic [DATA_WIDTH_BYTES-1:0] ram_w_strb,
   output logic                        ram_r_en,
   output logic [ADDR_WIDTH_BITS-1:0]  ram_r_addr,
   input  logic [DATA_WIDTH_BITS-1:0]  ram_r_data
);
   localparam logic [1:0] W_IDLE = 2'd0, W_EXEC = 2'd1, W_RESP = 2'd2;
   localparam logic [1:0] R_IDLE = 2'd0, R_EXEC = 2'd1, R_RESP = 2'd2;

   logic [1:0]                  r_wst, r_rst;
   logic                        r_aw_lat, r_w_lat;
   logic [AXI_ADDR_WIDTH-1:0]   r_awaddr, r_araddr;
   logic [DATA_WIDTH_BITS-1:0]  r_wdata, r_rdata;
   logic [DATA_WIDTH_BYTES-1:0] r_wstrb;
   logic                        w_aw_hs, w_w_hs, w_ar_hs, w_w_ok, w_r_ok;

   function automatic logic f_ok(input logic [AXI_ADDR_WIDTH-1:0] a);
`ifdef AXI_RAM_ALIGN_CHECK_EN
      return ((a >> LSB) < AXI_ADDR_WIDTH'(NUM_SLOTS)) &&
             ((a % AXI_ADDR_WIDTH'(DATA_WIDTH_BYTES)) == '0);
`else
      return (a >> LSB) < AXI_ADDR_WIDTH'(NUM_SLOTS);
`endif
   endfunction

   // Range is judged on the full latched address, which is held until the response retires.
   assign w_w_ok    = f_ok(r_awaddr);
   assign w_r_ok    = f_ok(r_araddr);
   assign s_awready = rst_n && r_wst == W_IDLE && !r_aw_lat;
   assign s_wready  = rst_n && r_wst == W_IDLE && !r_w_lat;
   assign s_arready = rst_n && r_rst == R_IDLE;
   assign w_aw_hs   = s_awvalid && s_awready;
   assign w_w_hs    = s_wvalid && s_wready;
   assign w_ar_hs   = s_arvalid && s_arready;

   assign s_bvalid   = rst_n && r_wst == W_RESP;
   assign s_bresp    = (s_bvalid && !w_w_ok) ? 2'b10 : 2'b00;
   assign ram_w_en   = rst_n && r_wst == W_EXEC && w_w_ok;
   assign ram_w_addr = ram_w_en ? r_awaddr[LSB +: ADDR_WIDTH_BITS] : '0;
   assign ram_w_data = ram_w_en ? r_wdata : '0;
   assign ram_w_strb = ram_w_en ? r_wstrb : '0;

   assign s_rvalid   = rst_n && r_rst == R_RESP;
   assign s_rresp    = (s_rvalid && !w_r_ok) ? 2'b10 : 2'b00;
   assign s_rdata    = rst_n ? r_rdata : '0;
   assign ram_r_en   = rst_n && r_rst == R_EXEC;
   assign ram_r_addr = ram_r_en ? r_araddr[LSB +: ADDR_WIDTH_BITS] : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wst    <= W_IDLE;
         r_aw_lat <= 1'b0;
         r_w_lat  <= 1'b0;
         r_awaddr <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
      end else begin
         case (r_wst)
            W_IDLE: begin
               if (w_aw_hs) begin
                  r_aw_lat <= 1'b1;
                  r_awaddr <= s_awaddr;
               end
               if (w_w_hs) begin
                  r_w_lat <= 1'b1;
                  r_wdata <= s_wdata;
                  r_wstrb <= s_wstrb;
               end
               if ((r_aw_lat || w_aw_hs) && (r_w_lat || w_w_hs)) r_wst <= W_EXEC;
            end
            W_EXEC: r_wst <= W_RESP;
            W_RESP: if (s_bready) begin
               r_wst    <= W_IDLE;
               r_aw_lat <= 1'b0;
               r_w_lat  <= 1'b0;
            end
            default: r_wst <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rst    <= R_IDLE;
         r_araddr <= '0;
         r_rdata  <= '0;
      end else begin
         case (r_rst)
            R_IDLE: if (w_ar_hs) begin
               r_araddr <= s_araddr;
               r_rst    <= R_EXEC;
            end
            R_EXEC: begin
               r_rdata <= w_r_ok ? ram_r_data : '0;
               r_rst   <= R_RESP;
            end
            R_RESP: if (s_rready) r_rst <= R_IDLE;
            default: r_rst <= R_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_lite_ram_ctrl.sv
// tb_axi_lite_ram_ctrl: directed self-checking bench with a byte-strobed RAM model.
module tb_axi_lite_ram_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata, ram_w_data, ram_r_data;
   logic [3:0]  s_wstrb, ram_w_strb;
   logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic        s_arvalid, s_arready, s_rvalid, s_rready, ram_w_en, ram_r_en;
   logic [1:0]  s_bresp, s_rresp;
   logic [2:0]  ram_w_addr, ram_r_addr;
   logic [31:0] mem [0:7];
   int          w_cnt = 0;
   int          n_vec = 0;
   int          n_err = 0;

   axi_lite_ram_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .ram_w_en(ram_w_en), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
      .ram_w_strb(ram_w_strb), .ram_r_en(ram_r_en), .ram_r_addr(ram_r_addr),
      .ram_r_data(ram_r_data)
   );

   always #5 clk = ~clk;

   assign ram_r_data = (ram_r_addr < 3'd6) ? mem[ram_r_addr] : 32'h0;

   always @(posedge clk) begin
      if (ram_w_en) begin
         w_cnt <= w_cnt + 1;
         for (int b = 0; b < 4; b++)
            if (ram_w_strb[b]) mem[ram_w_addr][8*b +: 8] <= ram_w_data[8*b +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic en, input logic [2:0] idx, input logic [1:0] resp);
      int c0;
      c0 = w_cnt;
      s_awaddr = a; s_wdata = d; s_wstrb = s;
      s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
      @(negedge clk);
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      chk("w_en", ram_w_en, en);
      chk("w_addr", ram_w_addr, en ? idx : 3'd0);
      chk("w_data", ram_w_data, en ? d : 32'h0);
      chk("w_strb", ram_w_strb, en ? s : 4'h0);
      @(negedge clk);
      chk("bvalid", s_bvalid, 1'b1);
      chk("bresp", s_bresp, resp);
      @(negedge clk);
      chk("b_done", {s_bvalid, s_awready, s_wready}, 3'b011);
      chk("w_cnt", w_cnt - c0, en ? 1 : 0);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
      s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
      #1 chk("arready", s_arready, 1'b1);
      @(negedge clk);
      s_arvalid = 1'b0;
      chk("r_en", ram_r_en, 1'b1);
      @(negedge clk);
      chk("rvalid", s_rvalid, 1'b1);
      chk("rdata", s_rdata, d);
      chk("rresp", s_rresp, resp);
      @(negedge clk);
      chk("r_done", {s_rvalid, s_arready}, 2'b01);
   endtask

   initial begin
      int c0;
      for (int i = 0; i < 8; i++) mem[i] = 32'h0;
      rst_n = 1'b0;
      s_awaddr = 0; s_wdata = 0; s_wstrb = 0; s_araddr = 0;
      s_awvalid = 0; s_wvalid = 0; s_bready = 0; s_arvalid = 0; s_rready = 0;
      repeat (3) begin
         @(negedge clk);
         chk("rst_out", {31'h0, |{s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata,
             s_rresp, s_rvalid, ram_w_en, ram_w_addr, ram_w_data, ram_w_strb, ram_r_en, ram_r_addr}}, 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("rdy_after_rst", {s_awready, s_wready, s_arready}, 3'b111);

      wr(32'h8, 32'hDEADBEEF, 4'hF, 1'b1, 3'd2, 2'b00);
      rd(32'h8, 32'hDEADBEEF, 2'b00);

      // same-cycle write and read of one word: the read sees the pre-write contents
      s_awaddr = 32'h8; s_wdata = 32'h12345678; s_wstrb = 4'hF; s_araddr = 32'h8;
      s_awvalid = 1; s_wvalid = 1; s_arvalid = 1; s_bready = 1; s_rready = 1;
      @(negedge clk);
      s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
      chk("cc_en", {ram_w_en, ram_r_en, ram_r_addr}, {2'b11, 3'd2});
      @(negedge clk);
      chk("cc_valid", {s_bvalid, s_rvalid}, 2'b11);
      chk("cc_old", s_rdata, 32'hDEADBEEF);
      @(negedge clk);
      chk("cc_done", {s_bvalid, s_rvalid}, 2'b00);
      rd(32'h8, 32'h12345678, 2'b00);

      c0 = w_cnt;
      s_wdata = 32'h11223344; s_wstrb = 4'b0101; s_wvalid = 1; s_bready = 1;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         s_wvalid = 0;
         chk("wready_low", s_wready, 1'b0);
         chk("w_early_en", ram_w_en, 1'b0);
      end
      s_awaddr = 32'h4; s_awvalid = 1;
      @(negedge clk);
      s_awvalid = 0;
      chk("wf_en", ram_w_en, 1'b1);
      chk("wf_addr", ram_w_addr, 3'd1);
      chk("wf_strb", ram_w_strb, 4'b0101);
      chk("wf_data", ram_w_data, 32'h11223344);
      @(negedge clk);
      chk("wf_b", {s_bvalid, s_bresp}, 3'b100);
      @(negedge clk);
      chk("wf_cnt", w_cnt - c0, 1);
      rd(32'h4, 32'h00220044, 2'b00);

      wr(32'h18, 32'h55555555, 4'hF, 1'b0, 3'd0, 2'b10);
      rd(32'h18, 32'h0, 2'b10);

      s_awaddr = 32'h0; s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF;
      s_awvalid = 1; s_wvalid = 1; s_bready = 0;
      @(negedge clk);
      s_awvalid = 0; s_wvalid = 0;
      chk("st_en", ram_w_en, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("st_b", {s_bvalid, s_bresp, s_awready}, 4'b1000);
         if (i == 0) begin
            s_araddr = 32'h0; s_arvalid = 1; s_rready = 1;
         end else if (i == 1) begin
            s_arvalid = 0;
            chk("st_ren", ram_r_en, 1'b1);
         end else if (i == 2) begin
            chk("st_r", {s_rvalid, s_rresp}, 3'b100);
            chk("st_rdata", s_rdata, 32'hCAFEF00D);
         end else if (i == 3) begin
            chk("st_rdone", s_rvalid, 1'b0);
         end
      end
      s_bready = 1;
      @(negedge clk);
      chk("st_done", {s_bvalid, s_awready}, 2'b01);

      // reset during the execute cycle must drop the write entirely
      c0 = w_cnt;
      s_awaddr = 32'h14; s_wdata = 32'hFFFFFFFF; s_wstrb = 4'hF;
      s_awvalid = 1; s_wvalid = 1; s_bready = 1;
      @(negedge clk);
      s_awvalid = 0; s_wvalid = 0;
      rst_n = 0;
      #1 chk("mr_wen", ram_w_en, 1'b0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("mr_state", {s_bvalid, s_awready, s_wready, s_arready}, 4'b0111);
      chk("mr_cnt", w_cnt - c0, 0);
      rd(32'h14, 32'h0, 2'b00);

`ifdef AXI_RAM_ALIGN_CHECK_EN
      wr(32'h6, 32'hA5A5A5A5, 4'hF, 1'b0, 3'd0, 2'b10);
      rd(32'h4, 32'h00220044, 2'b00);
      rd(32'h6, 32'h0, 2'b10);
`else
      wr(32'h6, 32'hA5A5A5A5, 4'hF, 1'b1, 3'd1, 2'b00);
      rd(32'h4, 32'hA5A5A5A5, 2'b00);
      rd(32'h6, 32'hA5A5A5A5, 2'b00);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
